// File: rtl/dht_poll_scheduler_if.sv
// ---------------------------------------------------------------------------
// dht_poll_scheduler_if
//
// Purpose:
//   Bundles the signals exchanged between the sensor poll scheduler and the
//   outside world: the enable from the host, the start/select/frame handshake
//   with the shared single-wire reader, and the published result record.
//   Signal names carry the direction as seen from the scheduler.
//
// Parameters:
//   CH_W          width of the channel index
//
// Signals:
//   i_en          1 = scheduling enabled
//   o_start       1-cycle pulse, reader begins its handshake on channel o_sel
//   o_sel         channel routed through the external data-line mux
//   i_frame       40-bit frame {hum_hi,hum_lo,tmp_hi,tmp_lo,chk} from reader
//   i_frame_done  1-cycle pulse from reader, i_frame valid
//   o_res_valid   1-cycle pulse, good result on o_res_*
//   o_res_err     1-cycle pulse, slot failed after all retries
//   o_res_ch      channel of the last result
//   o_res_hum     humidity word of the last good result
//   o_res_temp    temperature word of the last good result
//   o_busy        scheduler is working on a slot
//
// Modports:
//   master        the scheduler itself
//   slave         reader / host / consumer side
// ---------------------------------------------------------------------------
interface dht_poll_scheduler_if #(
    parameter int CH_W = 2
);
    logic            i_en;
    logic            o_start;
    logic [CH_W-1:0] o_sel;
    logic [39:0]     i_frame;
    logic            i_frame_done;
    logic            o_res_valid;
    logic            o_res_err;
    logic [CH_W-1:0] o_res_ch;
    logic [15:0]     o_res_hum;
    logic [15:0]     o_res_temp;
    logic            o_busy;

    modport master (
        input  i_en,
        input  i_frame,
        input  i_frame_done,
        output o_start,
        output o_sel,
        output o_res_valid,
        output o_res_err,
        output o_res_ch,
        output o_res_hum,
        output o_res_temp,
        output o_busy
    );

    modport slave (
        output i_en,
        output i_frame,
        output i_frame_done,
        input  o_start,
        input  o_sel,
        input  o_res_valid,
        input  o_res_err,
        input  o_res_ch,
        input  o_res_hum,
        input  o_res_temp,
        input  o_busy
    );
endinterface

// File: rtl/dht_poll_scheduler.sv
// ---------------------------------------------------------------------------
// dht_poll_scheduler
//
// Purpose:
//   Round-robin poll scheduler for the single-wire humidity/temperature
//   sensor reader. One reader is shared between NUM_CH sensors through an
//   external data-line mux driven by o_sel. Every SLOT_US cycles a slot is
//   requested; the scheduler then strobes the reader, waits for its 40-bit
//   frame, checks it, retries failed attempts up to MAX_RETRY times and
//   finally publishes either a result record or an error for that channel.
//
// Parameters:
//   NUM_CH        number of sensors polled (1..2**CH_W)
//   CH_W          width of the channel index
//   SLOT_US       slot length in clk1M cycles
//   TIMEOUT_US    max cycles from start pulse to frame_done
//   RETRY_GAP_US  idle cycles between a failed attempt and its retry
//   MAX_RETRY     retries after the first attempt (0..7)
//
// Ports:
//   clk1M         1 MHz clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   bus           dht_poll_scheduler_if.master (enable, reader handshake,
//                 result record, busy)
//
// Configuration macro:
//   DHT_CHECKSUM_EN  when defined, a frame is good only if its last byte is
//                    the mod-256 sum of the four data bytes; when undefined
//                    every received frame is good. CHECK costs one cycle in
//                    both builds so result latency does not change.
// ---------------------------------------------------------------------------
module dht_poll_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int SLOT_US      = 1_250_000,
    parameter int TIMEOUT_US   = 25_000,
    parameter int RETRY_GAP_US = 100_000,
    parameter int MAX_RETRY    = 2
) (
    input  logic                   clk1M,
    input  logic                   rst,
    dht_poll_scheduler_if.master   bus
);

    localparam int SLOT_W = (SLOT_US > 1) ? $clog2(SLOT_US) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_US + 1);
    localparam int GAP_W  = $clog2(RETRY_GAP_US + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_FAIL,
        S_GAP,
        S_PUBLISH,
        S_NEXT
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [SLOT_W-1:0] r_slotTimer;
    logic              r_pending;
    logic [WAIT_W-1:0] r_waitTimer;
    logic [GAP_W-1:0]  r_gapTimer;
    logic [2:0]        r_retry;
    logic [CH_W-1:0]   r_sel;
    logic [39:0]       r_frame;

    logic              r_resValid;
    logic              r_resErr;
    logic [CH_W-1:0]   r_resCh;
    logic [15:0]       r_resHum;
    logic [15:0]       r_resTemp;

    logic              w_slotWrap;
    logic              w_slotGo;
    logic              w_timeout;
    logic              w_retryLeft;
    logic              w_gapDone;
    logic              w_frameGood;
    logic [CH_W-1:0]   w_selNext;

    // The slot timer only advances while enabled, so a wrap can only be
    // flagged with en high; this is what freezes the schedule when en drops.
    assign w_slotWrap  = bus.i_en && (r_slotTimer == SLOT_W'(SLOT_US - 1));
    assign w_slotGo    = (r_state == S_IDLE) && r_pending && bus.i_en;
    assign w_timeout   = (r_waitTimer == WAIT_W'(TIMEOUT_US - 1));
    assign w_retryLeft = ({29'd0, r_retry} < 32'(MAX_RETRY));
    assign w_selNext   = (r_sel == CH_W'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;

    // The FAIL cycle already counts as the first idle cycle of the retry
    // gap, so GAP is left once RETRY_GAP_US-1 further cycles have elapsed.
    // This keeps exactly RETRY_GAP_US idle cycles between the end of the
    // failed attempt and the next start strobe.
    assign w_gapDone   = (r_gapTimer >= GAP_W'(RETRY_GAP_US - 1));

`ifdef DHT_CHECKSUM_EN
    logic [7:0] w_chkSum;
    assign w_chkSum    = r_frame[39:32] + r_frame[31:24] + r_frame[23:16] + r_frame[15:8];
    assign w_frameGood = (r_frame[7:0] == w_chkSum);
`else
    // Without checksum checking the chk byte is carried but never consumed.
    logic [7:0] w_unusedChk;
    assign w_unusedChk = r_frame[7:0];
    assign w_frameGood = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk1M) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A frame_done in the same cycle as the timeout is
    // tested first, so a late-but-valid frame is still accepted.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_pending && bus.i_en) begin
                    w_nextState = S_START;
                end
            end
            S_START: begin
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_frame_done) begin
                    w_nextState = S_CHECK;
                end else if (w_timeout) begin
                    w_nextState = S_FAIL;
                end
            end
            S_CHECK: begin
                w_nextState = w_frameGood ? S_PUBLISH : S_FAIL;
            end
            S_FAIL: begin
                w_nextState = w_retryLeft ? S_GAP : S_NEXT;
            end
            S_GAP: begin
                if (w_gapDone) begin
                    w_nextState = S_START;
                end
            end
            S_PUBLISH: begin
                w_nextState = S_NEXT;
            end
            S_NEXT: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state. The start strobe is masked by
    // rst so that a reset landing on the START cycle never reaches the reader.
    always_comb begin
        bus.o_start = (r_state == S_START) && !rst;
        bus.o_busy  = (r_state != S_IDLE);
    end

    // Slot timer and pending flag. A wrap sets pending even while a slot is
    // in progress; since pending is one level, a slot is only ever delayed.
    // A wrap coinciding with the IDLE hand-off wins so that request survives.
    always_ff @(posedge clk1M) begin
        if (rst) begin
            r_slotTimer <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (bus.i_en) begin
                r_slotTimer <= w_slotWrap ? '0 : r_slotTimer + 1'b1;
            end
            if (w_slotWrap) begin
                r_pending <= 1'b1;
            end else if (w_slotGo) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Attempt bookkeeping: retry count, wait/gap timers, frame capture and
    // channel advance.
    always_ff @(posedge clk1M) begin
        if (rst) begin
            r_retry     <= '0;
            r_waitTimer <= '0;
            r_gapTimer  <= '0;
            r_frame     <= '0;
            r_sel       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_slotGo) begin
                        r_retry <= '0;
                    end
                end
                S_START: begin
                    r_waitTimer <= '0;
                end
                S_WAIT: begin
                    r_waitTimer <= r_waitTimer + 1'b1;
                    if (bus.i_frame_done) begin
                        r_frame <= bus.i_frame;
                    end
                end
                S_FAIL: begin
                    if (w_retryLeft) begin
                        r_retry    <= r_retry + 3'd1;
                        r_gapTimer <= GAP_W'(1);
                    end
                end
                S_GAP: begin
                    r_gapTimer <= r_gapTimer + 1'b1;
                end
                S_NEXT: begin
                    r_sel <= w_selNext;
                end
                default: begin
                end
            endcase
        end
    end

    // Result record. The pulses are registered on the edge that enters
    // PUBLISH (good frame) or the final FAIL (retries exhausted), so they
    // are high exactly during those one-cycle states together with the
    // freshly loaded record. hum/temp are left untouched on an error.
    always_ff @(posedge clk1M) begin
        if (rst) begin
            r_resValid <= 1'b0;
            r_resErr   <= 1'b0;
            r_resCh    <= '0;
            r_resHum   <= '0;
            r_resTemp  <= '0;
        end else begin
            r_resValid <= 1'b0;
            r_resErr   <= 1'b0;
            if (r_state == S_CHECK && w_frameGood) begin
                r_resValid <= 1'b1;
                r_resCh    <= r_sel;
                r_resHum   <= r_frame[39:24];
                r_resTemp  <= r_frame[23:8];
            end else if (w_nextState == S_FAIL && !w_retryLeft) begin
                r_resErr   <= 1'b1;
                r_resCh    <= r_sel;
            end
        end
    end

    assign bus.o_sel       = r_sel;
    assign bus.o_res_valid = r_resValid;
    assign bus.o_res_err   = r_resErr;
    assign bus.o_res_ch    = r_resCh;
    assign bus.o_res_hum   = r_resHum;
    assign bus.o_res_temp  = r_resTemp;

endmodule
